// File: rtl/ahb_wr_feeder_pkg.sv
// Shared types for the AHB master write feeder.
// FSM state encoding and AHB HSIZE constants.
package ahb_wr_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

endpackage

// File: rtl/ahb_wr_feeder_fifo.sv
// Write-data FIFO for the AHB master write feeder.
// Registered storage, no bypass: a pushed word is poppable next cycle.
module ahb_wr_feeder_fifo #(
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [DATA_WDT-1:0] data_i,
    input  logic                pop_i,
    output logic [DATA_WDT-1:0] head_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WDT-1:0] mem_q [DEPTH];
    logic [AW:0]         wptr_q;
    logic [AW:0]         rptr_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array: written on accepted push only.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    // Read/write pointers with wrap bit; reset flushes the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_master_wr_feeder.sv
// Turns a write command plus a data stream into the ahb_master UI.
// UI registers only move on edges where i_next is high.
module ahb_master_wr_feeder
    import ahb_wr_feeder_pkg::*;
#(
    parameter int DATA_WDT   = 32,
    parameter int BEAT_WDT   = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int STALL_WDT  = 16
) (
    input  logic                 i_hclk,
    input  logic                 i_hreset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [31:0]          i_cmd_addr,
    input  logic [BEAT_WDT-1:0]  i_cmd_len,
    input  logic [2:0]           i_cmd_size,
    input  logic                 i_wdata_valid,
    output logic                 o_wdata_ready,
    input  logic [DATA_WDT-1:0]  i_wdata,
    input  logic                 i_next,
    output logic [31:0]          o_addr,
    output logic [2:0]           o_size,
    output logic                 o_wr,
    output logic [BEAT_WDT-1:0]  o_min_len,
    output logic                 o_cont,
    output logic                 o_dav,
    output logic [DATA_WDT-1:0]  o_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [STALL_WDT-1:0] o_stall_cnt
);

    feeder_state_e       state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [BEAT_WDT-1:0] len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [BEAT_WDT-1:0] cnt_q, cnt_d;
    logic [BEAT_WDT-1:0] cnt_next;

    logic [31:0]          uaddr_q, uaddr_d;
    logic [2:0]           usize_q, usize_d;
    logic                 wr_q, wr_d;
    logic [BEAT_WDT-1:0]  mlen_q, mlen_d;
    logic                 cont_q, cont_d;
    logic                 dav_q, dav_d;
    logic [DATA_WDT-1:0]  data_q, data_d;
    logic [STALL_WDT-1:0] stall_q, stall_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_WDT-1:0] fifo_head;
    logic                stall_inc;

    assign o_wdata_ready = !fifo_full;
    assign fifo_push     = i_wdata_valid && !fifo_full;

    ahb_wr_feeder_fifo #(
        .DATA_WDT (DATA_WDT),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_hclk),
        .rst_i   (i_hreset),
        .push_i  (fifo_push),
        .data_i  (i_wdata),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cnt_next = cnt_q + {{(BEAT_WDT-1){1'b0}}, dav_q};

    assign o_cmd_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_addr      = uaddr_q;
    assign o_size      = usize_q;
    assign o_wr        = wr_q;
    assign o_min_len   = mlen_q;
    assign o_cont      = cont_q;
    assign o_dav       = dav_q;
    assign o_data      = data_q;
    assign o_stall_cnt = stall_q;

    // Next-state, UI update and FIFO pop decision.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        uaddr_d   = uaddr_q;
        usize_d   = usize_q;
        wr_d      = wr_q;
        mlen_d    = mlen_q;
        cont_d    = cont_q;
        dav_d     = dav_q;
        data_d    = data_q;
        fifo_pop  = 1'b0;
        stall_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr;
                    len_d   = i_cmd_len;
                    size_d  = i_cmd_size;
                    cnt_d   = '0;
                    state_d = (i_cmd_len == '0) ? DONE : START;
                end
            end
            START: begin
                if (i_next) begin
                    wr_d    = 1'b1;
                    uaddr_d = addr_q;
                    usize_d = size_q;
                    mlen_d  = len_q;
                    cont_d  = 1'b0;
                    if (!fifo_empty) begin
                        dav_d    = 1'b1;
                        data_d   = fifo_head;
                        fifo_pop = 1'b1;
                    end else begin
                        dav_d     = 1'b0;
                        stall_inc = 1'b1;
                    end
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (i_next) begin
                    cnt_d  = cnt_next;
                    cont_d = 1'b1;
                    if (cnt_next == len_q) begin
                        wr_d    = 1'b0;
                        dav_d   = 1'b0;
                        cont_d  = 1'b0;
                        state_d = DONE;
                    end else if (!fifo_empty) begin
                        dav_d    = 1'b1;
                        data_d   = fifo_head;
                        fifo_pop = 1'b1;
                    end else begin
                        dav_d     = 1'b0;
                        stall_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating count of starved beats.
    always_comb begin
        stall_d = stall_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State, command latch, counters and UI registers.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            uaddr_q <= '0;
            usize_q <= '0;
            wr_q    <= 1'b0;
            mlen_q  <= '0;
            cont_q  <= 1'b0;
            dav_q   <= 1'b0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            uaddr_q <= uaddr_d;
            usize_q <= usize_d;
            wr_q    <= wr_d;
            mlen_q  <= mlen_d;
            cont_q  <= cont_d;
            dav_q   <= dav_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end

endmodule
